// File: rtl/sfx_request_queue_pkg.sv
// Shared constants for the sound-effect request queue: bus codes, IO register
// numbers, issuer state encoding and the HWDATA field layout.
package sfx_request_queue_pkg;

    localparam int SFXIDBITS = 8;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [3:0] H_SOUND_STATUS_IONUM  = 4'h1;
    localparam logic [3:0] H_SOUND_SOUNDFX_IONUM = 4'h2;

    localparam int HWDATA_MASK_LSB = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } sfxq_state_t;

    // Play carries the mask in [31:28] and the ID in the low bits; stop carries only the mask.
    function automatic logic [31:0] sfxq_wdata(input logic i_stop, input logic [3:0] i_mask,
                                               input logic [HWDATA_MASK_LSB-1:0] i_idExt);
        if (i_stop)
            return {28'b0, i_mask};
        return {i_mask, i_idExt};
    endfunction

endpackage

// File: rtl/sfxq_fifo.sv
// Parameterised synchronous FIFO with wrap-bit pointers and a flush that empties
// the queue while still accepting a push on the same edge.
module sfxq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wrPtr;
    logic [AW:0]  r_rdPtr;
    logic         w_doPush;
    logic         w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_level  = r_wrPtr - r_rdPtr;
    assign o_dout   = r_mem[r_rdPtr[AW-1:0]];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // A flush discards everything up to the write pointer, so it supersedes a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (i_flush)
                r_rdPtr <= r_wrPtr;
            else if (w_doPop)
                r_rdPtr <= r_rdPtr + PTR_ONE;
            if (w_doPush)
                r_wrPtr <= r_wrPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush)
            r_mem[r_wrPtr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/sfx_request_queue.sv
// Queued, rate-limited issuer turning play/stop requests into single AHB-Lite
// writes. Define SFXQ_STOP_FLUSH_EN to make an accepted stop discard pending entries.
module sfx_request_queue
    import sfx_request_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = SFXIDBITS,
    parameter int GAP   = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_stop,
    input  logic [3:0]               req_chmask,
    input  logic [ID_W-1:0]          req_id,
    output logic                     HSEL,
    output logic [3:0]               HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [31:0]              HWDATA,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int          EW       = ID_W + 5;
    localparam logic [3:0]  GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    sfxq_state_t     r_state;
    sfxq_state_t     w_nextState;
    logic [3:0]      r_gapCnt;
    logic [3:0]      w_nextGapCnt;
    logic [31:0]     r_hwdata;

    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic [EW-1:0]   w_din;
    logic [EW-1:0]   w_head;
    logic            w_headStop;
    logic [3:0]      w_headMask;
    logic [ID_W-1:0] w_headId;

    assign w_push    = req_valid && !w_full && (req_chmask != 4'b0);
    assign w_pop     = (r_state == ST_ADDR);
    assign w_din     = {req_stop, req_chmask, req_id};
    assign req_ready = !w_full;

`ifdef SFXQ_STOP_FLUSH_EN
    assign w_flush = w_push && req_stop;
`else
    assign w_flush = 1'b0;
`endif

    sfxq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (HCLK),
        .rst     (HRESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_headStop = w_head[EW-1];
    assign w_headMask = w_head[EW-2 -: 4];
    assign w_headId   = w_head[ID_W-1:0];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_gapCnt <= 4'd0;
        end else begin
            r_state  <= w_nextState;
            r_gapCnt <= w_nextGapCnt;
        end
    end

    // Leaving DATA or GAP reuses the IDLE decision so queued work issues without a dead cycle.
    always_comb begin
        w_nextState  = r_state;
        w_nextGapCnt = r_gapCnt;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty)
                    w_nextState = ST_ADDR;
            end
            ST_ADDR: begin
                w_nextState = ST_DATA;
            end
            ST_DATA: begin
                if (GAP > 0) begin
                    w_nextState  = ST_GAP;
                    w_nextGapCnt = GAP_LAST;
                end else begin
                    w_nextState = w_empty ? ST_IDLE : ST_ADDR;
                end
            end
            ST_GAP: begin
                if (r_gapCnt == 4'd0)
                    w_nextState = w_empty ? ST_IDLE : ST_ADDR;
                else
                    w_nextGapCnt = r_gapCnt - 4'd1;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            r_hwdata <= 32'd0;
        else if (r_state == ST_ADDR)
            r_hwdata <= sfxq_wdata(w_headStop, w_headMask, 28'(w_headId));
    end

    assign HSEL   = (r_state == ST_ADDR);
    assign HTRANS = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = (r_state != ST_ADDR) ? 4'd0 :
                    (w_headStop ? H_SOUND_STATUS_IONUM : H_SOUND_SOUNDFX_IONUM);
    assign HWRITE = 1'b1;
    assign HWDATA = r_hwdata;
    assign busy   = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_sfx_request_queue.sv
// Randomised self-checking bench for sfx_request_queue against a request-list
// model that tracks each transfer as a slot of 2+GAP bus cycles.
module tb_sfx_request_queue;
    import sfx_request_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = 2 + GAP;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_stop;
    logic [3:0]  req_chmask;
    logic [7:0]  req_id;
    logic        HSEL;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        busy;
    logic [2:0]  level;

    sfx_request_queue #(
        .DEPTH (DEPTH),
        .ID_W  (8),
        .GAP   (GAP)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_stop   (req_stop),
        .req_chmask (req_chmask),
        .req_id     (req_id),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .busy       (busy),
        .level      (level)
    );

    always #20 HCLK = ~HCLK;

    typedef struct {
        logic       stop;
        logic [3:0] mask;
        logic [7:0] id;
    } req_t;

    req_t        mq[$];
    int          slotPos;
    logic [31:0] expData;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] expectData(input req_t r);
        if (r.stop)
            return {28'd0, r.mask};
        return (32'(r.mask) << 28) | 32'(r.id);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkCycle();
        logic        inAddr;
        logic [3:0]  expAddr;
        inAddr  = (slotPos == 1);
        expAddr = 4'd0;
        if (inAddr)
            expAddr = mq[0].stop ? H_SOUND_STATUS_IONUM : H_SOUND_SOUNDFX_IONUM;
        checkOutput("HSEL", 32'(HSEL), 32'(inAddr));
        checkOutput("HTRANS", 32'(HTRANS), inAddr ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
        checkOutput("HADDR", 32'(HADDR), 32'(expAddr));
        checkOutput("HWDATA", HWDATA, expData);
        checkOutput("HWRITE", 32'(HWRITE), 32'd1);
        checkOutput("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
        checkOutput("level", 32'(level), 32'(mq.size()));
        checkOutput("busy", 32'(busy), 32'((mq.size() != 0) || (slotPos != 0)));
    endtask

    task automatic modelEdge(input logic v, input logic s, input logic [3:0] m, input logic [7:0] id);
        int   sz;
        logic accept;
        req_t r;
        sz     = mq.size();
        accept = v && (sz < DEPTH) && (m != 4'd0);
        if (slotPos == 1) begin
            expData = expectData(mq[0]);
            void'(mq.pop_front());
        end
        if (slotPos == 0 || slotPos == SLOT)
            slotPos = (sz != 0) ? 1 : 0;
        else
            slotPos++;
        if (accept) begin
`ifdef SFXQ_STOP_FLUSH_EN
            if (s)
                mq.delete();
`endif
            r.stop = s;
            r.mask = m;
            r.id   = id;
            mq.push_back(r);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [3:0] m, input logic [7:0] id);
        req_valid  = v;
        req_stop   = s;
        req_chmask = m;
        req_id     = id;
        @(posedge HCLK);
        modelEdge(v, s, m, id);
        @(negedge HCLK);
        checkCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic modelReset();
        mq.delete();
        slotPos = 0;
        expData = 32'd0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelReset();
        HRESET      = 1'b1;
        req_valid   = 1'b0;
        req_stop    = 1'b0;
        req_chmask  = 4'd0;
        req_id      = 8'd0;
        @(negedge HCLK);
        @(negedge HCLK);
        checkCycle();
        HRESET = 1'b0;

        // Single play, then a stop.
        applyStimulus(1'b1, 1'b0, 4'h1, 8'h05);
        idleCycles(6);
        applyStimulus(1'b1, 1'b1, 4'hF, 8'hAA);
        idleCycles(6);

        // Burst of five back-to-back requests.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 4'(i + 3), 8'(8'h10 + i));
        idleCycles(24);

        // Zero-mask request is swallowed.
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h33);
        idleCycles(3);

        // Three plays then a stop (flush behaviour depends on the build).
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 4'h2, 8'(8'h40 + i));
        applyStimulus(1'b1, 1'b1, 4'h6, 8'h00);
        idleCycles(20);

        // Reset asserted while a transfer is in its data phase.
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h77);
        for (int i = 0; i < 10 && slotPos != 2; i++)
            idleCycles(1);
        checkOutput("reached_data_phase", 32'(slotPos), 32'd2);
        #2 HRESET = 1'b1;
        #1;
        checkOutput("rst_HSEL", 32'(HSEL), 32'd0);
        checkOutput("rst_HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
        checkOutput("rst_HADDR", 32'(HADDR), 32'd0);
        checkOutput("rst_HWDATA", HWDATA, 32'd0);
        checkOutput("rst_HWRITE", 32'(HWRITE), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        modelReset();
        @(negedge HCLK);
        HRESET = 1'b0;
        idleCycles(8);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic       s;
            logic [3:0] m;
            v = ($urandom_range(0, 99) < 55);
            s = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            applyStimulus(v, s, m, 8'($urandom_range(0, 255)));
        end
        idleCycles(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
